// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// the hardwired zero-register address and the busy-count delta helper.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_delta_e;

    // Net effect of one cycle on a single busy bit. A set beats a clear
    // because the issuing instruction is the younger producer.
    function automatic cnt_delta_e busy_delta(input logic set,
                                              input logic clear,
                                              input logic prior);
        logic nxt;
        nxt = set | (prior & ~clear);
        if (nxt && !prior) begin
            return CNT_INC;
        end else if (!nxt && prior) begin
            return CNT_DEC;
        end
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// Write-pending scoreboard: one busy bit per register, an incrementally
// maintained busy count and a sticky error for issue to a busy register.
// Register 0 is never marked busy.
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]       busy_cnt,
    output logic                  err
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO    = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    logic             iss_v;
    logic             wa_v;
    logic             wb_v;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_next;
    logic             err_next;

    assign iss_v = iss_en && (iss_addr != ZERO);
    assign wa_v  = wa_en  && (wa_addr  != ZERO);
    assign wb_v  = wb_en  && (wb_addr  != ZERO);

    // Next busy vector, count and error; the count only looks at the (at most
    // three) touched addresses, each counted once.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_v) set_vec[iss_addr] = 1'b1;
        if (wa_v)  clr_vec[wa_addr]  = 1'b1;
        if (wb_v)  clr_vec[wb_addr]  = 1'b1;
        busy_next = set_vec | (busy & ~clr_vec);

        cnt_next = busy_cnt;
        if (iss_v) begin
            if (busy_delta(1'b1, clr_vec[iss_addr], busy[iss_addr]) == CNT_INC)
                cnt_next = cnt_next + CNT_ONE;
        end
        if (wa_v && !(iss_v && wa_addr == iss_addr)) begin
            if (busy_delta(set_vec[wa_addr], 1'b1, busy[wa_addr]) == CNT_DEC)
                cnt_next = cnt_next - CNT_ONE;
        end
        if (wb_v && !(iss_v && wb_addr == iss_addr) && !(wa_v && wb_addr == wa_addr)) begin
            if (busy_delta(set_vec[wb_addr], 1'b1, busy[wb_addr]) == CNT_DEC)
                cnt_next = cnt_next - CNT_ONE;
        end

        err_next = err | (iss_v & busy[iss_addr]);
    end

    // Scoreboard state; reset discards everything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            err      <= err_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports (A = ALU, B = load, B wins
// on collision), NUM_RD combinational read ports and a busy scoreboard.
// Optional build macro: REGFILE_BYPASS_EN adds same-cycle write-to-read
// forwarding of data and busy state.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     err
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] rd_a;

    regfile_sb_score #(.ADDR_W(ADDR_W)) u_score (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt),
        .err      (err)
    );

    // Data array: port B is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wa_en && wa_addr != ZERO) regs[wa_addr] <= wa_data;
            if (wb_en && wb_addr != ZERO) regs[wb_addr] <= wb_data;
        end
    end

    // Read muxing; register 0 always reads as zero and is never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = (rd_a == ZERO) ? '0 : regs[rd_a];
            rd_busy[i] = busy[rd_a];
`ifdef REGFILE_BYPASS_EN
            if (rd_a != ZERO) begin
                if (wb_en && wb_addr == rd_a) begin
                    rd_data[i*DATA_W +: DATA_W] = wb_data;
                end else if (wa_en && wa_addr == rd_a) begin
                    rd_data[i*DATA_W +: DATA_W] = wa_data;
                end
                if (((wb_en && wb_addr == rd_a) || (wa_en && wa_addr == rd_a)) &&
                    !(iss_en && iss_addr == rd_a)) begin
                    rd_busy[i] = 1'b0;
                end
            end
`endif
        end
    end

endmodule
